mips_decode_execute_unit: RTL and testbench

Combined main decoder, ALU-control decoder and 32-bit ALU for the MIPS core. It converts one instruction word plus the two GPR read operands into datapath control strobes, the immediate operand, the ALU result and the zero flag in the same cycle. It also holds an EX/MEM pipeline register stage. It sits between the GPR file and data memory/IFU: its combinational outputs drive single-cycle paths, and its registered outputs feed the next stage.

---
 rtl/mips_decode_execute_unit_if.sv | 46 ++++
 rtl/mips_decode_execute_unit.sv | 160 ++++++++++++++++
 tb/tb_mips_decode_execute_unit.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/mips_decode_execute_unit_if.sv
// rtl/mips_decode_execute_unit_if.sv - instruction/operand inputs and decode/ALU/EX-stage outputs
interface mips_decode_execute_unit_if #(
    parameter int DATA_WIDTH = 32
);
    logic [31:0]           instruction;
    logic [DATA_WIDTH-1:0] read_data_1;
    logic [DATA_WIDTH-1:0] read_data_2;
    logic                  branch_eq;
    logic                  branch_ne;
    logic                  jump;
    logic                  memory_read;
    logic                  memory_write;
    logic                  memory_to_register;
    logic                  register_destination;
    logic                  register_write;
    logic                  alu_source;
    logic                  shift_upper;
    logic [1:0]            alu_opcode;
    logic [3:0]            alu_control_signal;
    logic [DATA_WIDTH-1:0] extended_immediate;
    logic [4:0]            write_address;
    logic [DATA_WIDTH-1:0] alu_result;
    logic                  zero_output;
    logic [DATA_WIDTH-1:0] ex_alu_result_q;
    logic                  ex_zero_q;
    logic                  ex_register_write_q;
    logic [4:0]            ex_write_address_q;

    modport master (
        output instruction, read_data_1, read_data_2,
        input  branch_eq, branch_ne, jump, memory_read, memory_write,
               memory_to_register, register_destination, register_write,
               alu_source, shift_upper, alu_opcode, alu_control_signal,
               extended_immediate, write_address, alu_result, zero_output,
               ex_alu_result_q, ex_zero_q, ex_register_write_q, ex_write_address_q
    );

    modport slave (
        input  instruction, read_data_1, read_data_2,
        output branch_eq, branch_ne, jump, memory_read, memory_write,
               memory_to_register, register_destination, register_write,
               alu_source, shift_upper, alu_opcode, alu_control_signal,
               extended_immediate, write_address, alu_result, zero_output,
               ex_alu_result_q, ex_zero_q, ex_register_write_q, ex_write_address_q
    );
endinterface

// File: rtl/mips_decode_execute_unit.sv
// rtl/mips_decode_execute_unit.sv - MIPS main decoder, ALU control, 32-bit ALU and EX/MEM register
module mips_decode_execute_unit #(
    parameter int DATA_WIDTH = 32
) (
    input logic                     system_clock,
    input logic                     reset,
    mips_decode_execute_unit_if.slave bus
);
    logic [5:0]            w_opcode;
    logic [5:0]            w_funct;
    logic [15:0]           w_imm;
    logic                  w_branch_eq, w_branch_ne, w_jump, w_memory_read, w_memory_write;
    logic                  w_memory_to_register, w_register_destination, w_register_write;
    logic                  w_alu_source, w_shift_upper;
    logic [1:0]            w_alu_opcode;
    logic [3:0]            w_alu_control;
    logic [DATA_WIDTH-1:0] w_ext_imm, w_operand_a, w_operand_b, w_alu_result;
    logic [4:0]            w_write_address;
    logic                  w_zero;
    logic [4:0]            w_unused_rs;

    logic [DATA_WIDTH-1:0] r_ex_alu_result;
    logic                  r_ex_zero;
    logic                  r_ex_register_write;
    logic [4:0]            r_ex_write_address;

    assign w_opcode    = bus.instruction[31:26];
    assign w_funct     = bus.instruction[5:0];
    assign w_imm       = bus.instruction[15:0];
    assign w_unused_rs = bus.instruction[25:21];

    always_comb begin
        w_branch_eq            = 1'b0;
        w_branch_ne            = 1'b0;
        w_jump                 = 1'b0;
        w_memory_read          = 1'b0;
        w_memory_write         = 1'b0;
        w_memory_to_register   = 1'b0;
        w_register_destination = 1'b0;
        w_register_write       = 1'b0;
        w_alu_source           = 1'b0;
        w_shift_upper          = 1'b0;
        w_alu_opcode           = 2'b00;
        case (w_opcode)
            6'b000000: begin
                w_register_destination = 1'b1;
                w_register_write       = 1'b1;
                w_alu_opcode           = 2'b10;
            end
            6'b100011: begin
                w_alu_source         = 1'b1;
                w_memory_read        = 1'b1;
                w_memory_to_register = 1'b1;
                w_register_write     = 1'b1;
            end
            6'b101011: begin
                w_alu_source   = 1'b1;
                w_memory_write = 1'b1;
            end
            6'b000100: begin
                w_branch_eq  = 1'b1;
                w_alu_opcode = 2'b01;
            end
            6'b000101: begin
                w_branch_ne  = 1'b1;
                w_alu_opcode = 2'b01;
            end
            6'b001000: begin
                w_alu_source     = 1'b1;
                w_register_write = 1'b1;
            end
            6'b001111: begin
                w_alu_source     = 1'b1;
                w_register_write = 1'b1;
                w_shift_upper    = 1'b1;
            end
            6'b000010: w_jump = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        w_alu_control = 4'b0010;
        case (w_alu_opcode)
            2'b01: w_alu_control = 4'b0110;
            2'b10: begin
                case (w_funct)
                    6'b100010, 6'b100011: w_alu_control = 4'b0110;
                    6'b100100:            w_alu_control = 4'b0000;
                    6'b100101:            w_alu_control = 4'b0001;
                    6'b100110:            w_alu_control = 4'b0011;
                    6'b100111:            w_alu_control = 4'b1100;
                    6'b101010:            w_alu_control = 4'b0111;
                    6'b101011:            w_alu_control = 4'b1000;
                    default:              w_alu_control = 4'b0010;
                endcase
            end
            default: w_alu_control = 4'b0010;
        endcase
    end

    // lui relies on the ALU adding the pre-shifted immediate to rs=$0
    assign w_ext_imm = w_shift_upper ? {w_imm, {(DATA_WIDTH-16){1'b0}}}
                                     : {{(DATA_WIDTH-16){w_imm[15]}}, w_imm};
    assign w_operand_a = bus.read_data_1;
    assign w_operand_b = w_alu_source ? w_ext_imm : bus.read_data_2;

    always_comb begin
        w_alu_result = '0;
        case (w_alu_control)
            4'b0010: w_alu_result = w_operand_a + w_operand_b;
            4'b0110: w_alu_result = w_operand_a - w_operand_b;
            4'b0000: w_alu_result = w_operand_a & w_operand_b;
            4'b0001: w_alu_result = w_operand_a | w_operand_b;
            4'b0011: w_alu_result = w_operand_a ^ w_operand_b;
            4'b1100: w_alu_result = ~(w_operand_a | w_operand_b);
            4'b0111: w_alu_result = {{(DATA_WIDTH-1){1'b0}}, $signed(w_operand_a) < $signed(w_operand_b)};
            4'b1000: w_alu_result = {{(DATA_WIDTH-1){1'b0}}, w_operand_a < w_operand_b};
            default: w_alu_result = '0;
        endcase
    end

    assign w_zero          = (w_alu_result == '0);
    assign w_write_address = w_register_destination ? bus.instruction[15:11] : bus.instruction[20:16];

    always_ff @(posedge system_clock) begin
        if (reset) begin
            r_ex_alu_result     <= '0;
            r_ex_zero           <= 1'b0;
            r_ex_register_write <= 1'b0;
            r_ex_write_address  <= '0;
        end else begin
            r_ex_alu_result     <= w_alu_result;
            r_ex_zero           <= w_zero;
            r_ex_register_write <= w_register_write;
            r_ex_write_address  <= w_write_address;
        end
    end

    assign bus.branch_eq            = w_branch_eq;
    assign bus.branch_ne            = w_branch_ne;
    assign bus.jump                 = w_jump;
    assign bus.memory_read          = w_memory_read;
    assign bus.memory_write         = w_memory_write;
    assign bus.memory_to_register   = w_memory_to_register;
    assign bus.register_destination = w_register_destination;
    assign bus.register_write       = w_register_write;
    assign bus.alu_source           = w_alu_source;
    assign bus.shift_upper          = w_shift_upper;
    assign bus.alu_opcode           = w_alu_opcode;
    assign bus.alu_control_signal   = w_alu_control;
    assign bus.extended_immediate   = w_ext_imm;
    assign bus.write_address        = w_write_address;
    assign bus.alu_result           = w_alu_result;
    assign bus.zero_output          = w_zero;
    assign bus.ex_alu_result_q      = r_ex_alu_result;
    assign bus.ex_zero_q            = r_ex_zero;
    assign bus.ex_register_write_q  = r_ex_register_write;
    assign bus.ex_write_address_q   = r_ex_write_address;
endmodule

// File: tb/tb_mips_decode_execute_unit.sv
// tb/tb_mips_decode_execute_unit.sv - scoreboard bench with reference decode/ALU model
module tb_mips_decode_execute_unit;
    localparam int N_DIRECTED = 14;
    localparam int N_RANDOM   = 400;
    localparam int N_TOTAL    = N_DIRECTED + N_RANDOM;

    logic clk;
    logic rst;
    mips_decode_execute_unit_if #(.DATA_WIDTH(32)) bus_if ();

    mips_decode_execute_unit #(.DATA_WIDTH(32)) dut (
        .system_clock (clk),
        .reset        (rst),
        .bus          (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  strobes;
        logic [1:0]  aop;
        logic [3:0]  ctrl;
        logic [31:0] ext;
        logic [4:0]  wa;
        logic [31:0] res;
        logic        zero;
        logic [31:0] ex_res;
        logic        ex_zero;
        logic        ex_rw;
        logic [4:0]  ex_wa;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic [3:0] code_of(string name);
        case (name)
            "ADD":  return 4'd2;
            "SUB":  return 4'd6;
            "AND":  return 4'd0;
            "OR":   return 4'd1;
            "XOR":  return 4'd3;
            "NOR":  return 4'd12;
            "SLT":  return 4'd7;
            "SLTU": return 4'd8;
            default: return 4'd2;
        endcase
    endfunction

    function automatic exp_t model(logic [31:0] instr, logic [31:0] a, logic [31:0] b, logic r);
        exp_t e;
        logic [5:0] op;
        logic [5:0] fn;
        logic [15:0] imm;
        logic beq, bne, j, mr, mw, m2r, rdst, rw, asrc, su;
        logic [1:0] aop;
        logic [31:0] opb;
        string oper;
        op = instr[31:26];
        fn = instr[5:0];
        imm = instr[15:0];
        {beq, bne, j, mr, mw, m2r, rdst, rw, asrc, su} = '0;
        aop = 2'd0;
        if (op == 6'h00) begin rdst = 1; rw = 1; aop = 2'd2; end
        else if (op == 6'h23) begin asrc = 1; mr = 1; m2r = 1; rw = 1; end
        else if (op == 6'h2b) begin asrc = 1; mw = 1; end
        else if (op == 6'h04) begin beq = 1; aop = 2'd1; end
        else if (op == 6'h05) begin bne = 1; aop = 2'd1; end
        else if (op == 6'h08) begin asrc = 1; rw = 1; end
        else if (op == 6'h0f) begin asrc = 1; rw = 1; su = 1; end
        else if (op == 6'h02) begin j = 1; end
        oper = "ADD";
        if (aop == 2'd1) oper = "SUB";
        else if (aop == 2'd2) begin
            if (fn == 6'h22 || fn == 6'h23) oper = "SUB";
            else if (fn == 6'h24) oper = "AND";
            else if (fn == 6'h25) oper = "OR";
            else if (fn == 6'h26) oper = "XOR";
            else if (fn == 6'h27) oper = "NOR";
            else if (fn == 6'h2a) oper = "SLT";
            else if (fn == 6'h2b) oper = "SLTU";
        end
        if (su) e.ext = 32'(imm) * 32'd65536;
        else    e.ext = 32'($signed(imm));
        opb = asrc ? e.ext : b;
        case (oper)
            "ADD":  e.res = a + opb;
            "SUB":  e.res = a - opb;
            "AND":  e.res = a & opb;
            "OR":   e.res = a | opb;
            "XOR":  e.res = a ^ opb;
            "NOR":  e.res = ~(a | opb);
            "SLT":  e.res = ($signed(a) < $signed(opb)) ? 32'd1 : 32'd0;
            "SLTU": e.res = (a < opb) ? 32'd1 : 32'd0;
            default: e.res = 32'd0;
        endcase
        e.strobes = {beq, bne, j, mr, mw, m2r, rdst, rw, asrc, su};
        e.aop     = aop;
        e.ctrl    = code_of(oper);
        e.wa      = rdst ? instr[15:11] : instr[20:16];
        e.zero    = (e.res == 32'd0);
        e.ex_res  = r ? 32'd0 : e.res;
        e.ex_zero = r ? 1'b0 : e.zero;
        e.ex_rw   = r ? 1'b0 : rw;
        e.ex_wa   = r ? 5'd0 : e.wa;
        return e;
    endfunction

    task automatic chk(string name, logic [31:0] got, logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %0s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic drive(logic [31:0] instr, logic [31:0] a, logic [31:0] b, logic r);
        @(posedge clk);
        #1;
        bus_if.instruction = instr;
        bus_if.read_data_1 = a;
        bus_if.read_data_2 = b;
        rst = r;
        exp_q.push_back(model(instr, a, b, r));
    endtask

    function automatic logic [31:0] rinstr(logic [5:0] op, logic [4:0] rd, logic [5:0] fn);
        return {op, 5'd1, 5'd2, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] iinstr(logic [5:0] op, logic [4:0] rt, logic [15:0] imm);
        return {op, 5'd3, rt, imm};
    endfunction

    // stimulus: reset, directed test-plan cases, then randomized traffic
    initial begin
        logic [5:0] ops [11];
        logic [5:0] fns [11];
        logic [31:0] instr, a, b;
        rst = 1'b1;
        bus_if.instruction = '0;
        bus_if.read_data_1 = '0;
        bus_if.read_data_2 = '0;
        ops = '{6'h00, 6'h00, 6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h08, 6'h0f, 6'h02, 6'h3f};
        fns = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b, 6'h00};
        drive($urandom, $urandom, $urandom, 1'b1);
        drive($urandom, $urandom, $urandom, 1'b1);
        drive(rinstr(6'h00, 5'd9, 6'h20), 32'd5, 32'd7, 1'b0);
        drive(iinstr(6'h04, 5'd2, 16'h0010), 32'd3, 32'd3, 1'b0);
        drive(iinstr(6'h04, 5'd2, 16'h0010), 32'd3, 32'd4, 1'b0);
        drive(iinstr(6'h23, 5'd4, 16'hFFFC), 32'h100, $urandom, 1'b0);
        drive(iinstr(6'h0f, 5'd6, 16'h1234), 32'd0, $urandom, 1'b0);
        drive(rinstr(6'h00, 5'd10, 6'h2a), 32'hFFFFFFFF, 32'd1, 1'b0);
        drive(rinstr(6'h00, 5'd11, 6'h2b), 32'hFFFFFFFF, 32'd1, 1'b0);
        drive(rinstr(6'h00, 5'd12, 6'h27), 32'd0, 32'd0, 1'b0);
        drive({6'h3f, 26'h2AB_CDEF}, $urandom, $urandom, 1'b0);
        drive(iinstr(6'h05, 5'd2, 16'h0004), 32'd9, 32'd9, 1'b0);
        drive(rinstr(6'h00, 5'd13, 6'h3d), 32'd40, 32'd2, 1'b1);
        drive(iinstr(6'h08, 5'd14, 16'h8000), 32'd1, 32'd0, 1'b0);
        for (int k = 0; k < N_RANDOM; k++) begin
            instr = $urandom;
            instr[31:26] = ops[$urandom_range(0, 10)];
            if ($urandom_range(0, 9) == 0) instr[31:26] = 6'($urandom);
            if ($urandom_range(0, 4) != 0) instr[5:0] = fns[$urandom_range(0, 10)];
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) b = a;
            if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 8));
            drive(instr, a, b, $urandom_range(0, 19) == 0);
        end
    end

    // monitor: one expected entry per cycle, checked mid-cycle
    initial begin
        exp_t e, prev;
        bit   have_prev = 0;
        for (int k = 0; k < N_TOTAL; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL queue_empty: got 0 entries expected 1 at item %0d", k);
                continue;
            end
            e = exp_q.pop_front();
            chk("strobes", 32'({bus_if.branch_eq, bus_if.branch_ne, bus_if.jump, bus_if.memory_read,
                                bus_if.memory_write, bus_if.memory_to_register, bus_if.register_destination,
                                bus_if.register_write, bus_if.alu_source, bus_if.shift_upper}), 32'(e.strobes));
            chk("alu_opcode", 32'(bus_if.alu_opcode), 32'(e.aop));
            chk("alu_control_signal", 32'(bus_if.alu_control_signal), 32'(e.ctrl));
            chk("extended_immediate", bus_if.extended_immediate, e.ext);
            chk("write_address", 32'(bus_if.write_address), 32'(e.wa));
            chk("alu_result", bus_if.alu_result, e.res);
            chk("zero_output", 32'(bus_if.zero_output), 32'(e.zero));
            if (have_prev) begin
                chk("ex_alu_result_q", bus_if.ex_alu_result_q, prev.ex_res);
                chk("ex_zero_q", 32'(bus_if.ex_zero_q), 32'(prev.ex_zero));
                chk("ex_register_write_q", 32'(bus_if.ex_register_write_q), 32'(prev.ex_rw));
                chk("ex_write_address_q", 32'(bus_if.ex_write_address_q), 32'(prev.ex_wa));
            end
            prev = e;
            have_prev = 1;
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
